// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC ownership, pipelined imem requests
// and an in-order fetch queue feeding decode.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non-word-aligned target pushes a single marker
//               entry (NOP, id_misalign_o=1) and halts fetch until the next redirect.
//   undefined : redirect target bits [1:0] are forced to zero; no id_misalign_o port.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   imem_req_o / imem_addr_o    fetch request and its address (current fetch PC)
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i / imem_rdata_i in-order response
//   redirect_i / redirect_pc_i  flush queue and restart fetch at a new PC
//   id_valid_o / id_ready_i     decode handshake for the queue head
//   id_instr_o / id_pc_o        head instruction and its PC
//   id_misalign_o               head is a misaligned-target marker (feature build only)

module fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         FQ_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic [PC_WIDTH-1:0]    id_pc_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                   id_misalign_o
`endif
);

    localparam int unsigned IDX_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned SUM_W = PTR_W + 2;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

    // Queue storage and bookkeeping
    logic [PC_WIDTH-1:0]    r_q_pc    [FQ_DEPTH];
    logic [INSTR_WIDTH-1:0] r_q_instr [FQ_DEPTH];
    logic [FQ_DEPTH-1:0]    r_q_arrived;
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PTR_W-1:0]       r_alloc;
    logic [PTR_W-1:0]       r_fill;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_inflight;
    logic [PTR_W-1:0]       r_discard;

    logic [PTR_W-1:0]       w_occ;
    logic [SUM_W-1:0]       w_credit_used;
    logic                   w_halt;
    logic                   w_grant;
    logic                   w_drop;
    logic                   w_fill_wr;
    logic                   w_resp_any;
    logic                   w_pop;
    logic [PC_WIDTH-1:0]    w_redir_pc;
    logic [PTR_W-1:0]       w_redir_discard;
    logic [IDX_W-1:0]       w_head_idx;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic [IDX_W-1:0]       w_fill_idx;

`ifdef FETCH_MISALIGN_CHK_EN
    logic [FQ_DEPTH-1:0]    r_q_misalign;
    logic                   r_halted;
    assign w_halt     = r_halted;
    assign w_redir_pc = redirect_pc_i;
`else
    logic                   w_unused_pc_lsb;
    assign w_halt          = 1'b0;
    assign w_redir_pc      = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc_i[1:0];
`endif

    assign w_head_idx  = r_head[IDX_W-1:0];
    assign w_alloc_idx = r_alloc[IDX_W-1:0];
    assign w_fill_idx  = r_fill[IDX_W-1:0];

    // Arrived-but-unpopped entries; allocated-not-arrived entries are covered by inflight
    assign w_occ         = r_fill - r_head;
    assign w_credit_used = SUM_W'(w_occ) + SUM_W'(r_inflight) + SUM_W'(r_discard);

    assign imem_req_o  = !rst && !redirect_i && !w_halt && (w_credit_used < SUM_W'(FQ_DEPTH));
    assign imem_addr_o = r_fetch_pc;
    assign w_grant     = imem_req_o && imem_gnt_i;

    // Stale responses drain first; responses with nothing outstanding are ignored
    assign w_drop     = imem_rvalid_i && (r_discard != '0);
    assign w_fill_wr  = imem_rvalid_i && (r_discard == '0) && (r_inflight != '0);
    assign w_resp_any = w_drop || w_fill_wr;

    // Every outstanding response becomes stale; one arriving this cycle is consumed now
    assign w_redir_discard = r_discard + r_inflight - PTR_W'(w_resp_any);

    assign id_valid_o = r_q_arrived[w_head_idx] && (w_occ != '0);
    assign id_instr_o = r_q_instr[w_head_idx];
    assign id_pc_o    = r_q_pc[w_head_idx];
    assign w_pop      = id_valid_o && id_ready_i;

`ifdef FETCH_MISALIGN_CHK_EN
    assign id_misalign_o = id_valid_o && r_q_misalign[w_head_idx];
`endif

    // Fetch PC, pointers, counters and queue entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_alloc     <= '0;
            r_fill      <= '0;
            r_head      <= '0;
            r_inflight  <= '0;
            r_discard   <= '0;
            r_q_arrived <= '0;
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            r_q_misalign <= '0;
            r_halted     <= 1'b0;
`endif
        end else if (redirect_i) begin
            r_fetch_pc  <= w_redir_pc;
            r_alloc     <= '0;
            r_fill      <= '0;
            r_head      <= '0;
            r_inflight  <= '0;
            r_discard   <= w_redir_discard;
            r_q_arrived <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            r_q_misalign <= '0;
            r_halted     <= 1'b0;
            // Misaligned target: park a ready marker at slot 0 and stop fetching
            if (redirect_pc_i[1:0] != 2'b00) begin
                r_q_pc[0]       <= redirect_pc_i;
                r_q_instr[0]    <= NOP_INSTR;
                r_q_misalign[0] <= 1'b1;
                r_q_arrived[0]  <= 1'b1;
                r_alloc         <= PTR_W'(1);
                r_fill          <= PTR_W'(1);
                r_halted        <= 1'b1;
            end
`endif
        end else begin
            if (w_grant) begin
                r_q_pc[w_alloc_idx]      <= r_fetch_pc;
                r_q_arrived[w_alloc_idx] <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                r_q_misalign[w_alloc_idx] <= 1'b0;
`endif
                r_alloc    <= r_alloc + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
            end
            if (w_fill_wr) begin
                r_q_instr[w_fill_idx]   <= imem_rdata_i;
                r_q_arrived[w_fill_idx] <= 1'b1;
                r_fill                  <= r_fill + PTR_W'(1);
            end
            r_inflight <= r_inflight + PTR_W'(w_grant) - PTR_W'(w_fill_wr);
            if (w_drop) begin
                r_discard <= r_discard - PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

endmodule
